set_mode_ctrl: RTL and testbench
================================

// Module: set_mode_ctrl
// PURPOSE
// - Front-panel sequencer for the alarm-clock datapath.
// - Turns three buttons (mode, adv, alarm toggle) into the level/pulse controls
//   the counter chain consumes: timeset, alarmset, minadv/hrsadv/dayadv/
//   dateadv/monthadv, alarmon.
// - Provides press-and-hold auto-repeat, an idle timeout back to RUN and
//   optional alarm snooze. Sits between the buttons and the clock top level.
// PARAMETERS
// - TIMEOUT   30  cycles without any button edge/hold in a set state before forced return to RUN (>=2)
// - HOLD_DLY  2   cycles adv must stay high after its press edge before auto-repeat starts (>=1)
// - SNOOZE_CYC 300 cycles buzz is masked after a snooze press (used only with SNOOZE_EN)
// PORTS
// - clk         in   1  clock, rising edge (1 Hz Pulse in the clock top level)
// - rst         in   1  reset, asynchronous, active-low
// - mode_btn    in   1  step to next set state (rising edge)
// - adv_btn     in   1  advance the field selected by state (edge + hold repeat)
// - alarm_tgl   in   1  toggle alarmon (rising edge)
// - snooze_btn  in   1  snooze request (ignored unless SNOOZE_EN)
// - buzz_in     in   1  raw alarm match/buzz from the alarm comparator
// - timeset     out  1  high in SET_MIN..SET_MONTH
// - alarmset    out  1  high in AL_MIN, AL_HRS
// - minadv      out  1  advance pulse, SET_MIN or AL_MIN
// - hrsadv      out  1  advance pulse, SET_HRS or AL_HRS
// - dayadv      out  1  advance pulse, SET_DAY
// - dateadv     out  1  advance pulse, SET_DATE
// - monthadv    out  1  advance pulse, SET_MONTH
// - alarmon     out  1  alarm arm flag
// - buzz_out    out  1  buzz after snooze masking
// - mode_st     out  3  current state code (debug/display)
// BEHAVIOUR
// - Reset (rst=0, async): state=RUN, all adv outputs 0, alarmon=0, idle/hold/snooze counters 0.
//   Button edge-detect regs reset to 1, so a button held through reset gives no edge until released and re-pressed.
// - Edge = btn high now, low previous cycle (sampled on clk). All outputs registered; 1-cycle latency from
//   sampled edge to output change.
// - States / mode_st: RUN=0, SET_MIN=1, SET_HRS=2, SET_DAY=3, SET_DATE=4, SET_MONTH=5, AL_MIN=6, AL_HRS=7.
//   Each mode_btn edge steps code+1; AL_HRS wraps to RUN.
// - timeset = (mode_st in 1..5); alarmset = (mode_st in 6..7); both 0 in RUN.
// - Advance: adv edge in a set state -> one-cycle pulse on that state's adv output.
//   - If adv stays high, hold counter counts.
//   - Once adv has been high HOLD_DLY cycles after the edge, the pulse repeats every cycle until release.
//   - Release clears the hold counter.
//   - In RUN, adv is ignored.
//   - At most one adv output high in any cycle.
// - Simultaneous mode and adv edges: mode wins. State steps, no adv pulse, hold counter cleared;
//   a still-held adv does not repeat in the new state until re-pressed.
// - Idle timeout: in a set state, the idle counter clears on any mode/adv/alarm_tgl edge or while adv is held;
//   otherwise it increments.
//   - On reaching TIMEOUT: state=RUN, adv outputs 0, counter cleared.
//   - Counter is held at 0 in RUN.
// - alarm_tgl edge toggles alarmon in any state; independent of mode/adv.
// - Counter widths $clog2(max+1); no overflow: idle saturates at TIMEOUT, hold saturates at HOLD_DLY.
// CONFIGURATION
// - SNOOZE_EN defined:
//   - snooze_btn edge while buzz_in=1 and alarmon=1 loads the snooze counter with SNOOZE_CYC.
//   - buzz_out = buzz_in & alarmon & (snooze counter==0); counter decrements to 0.
//   - alarm_tgl to off clears the counter.
//   - A snooze edge while already snoozing reloads SNOOZE_CYC.
// - SNOOZE_EN undefined: snooze_btn unused, no snooze counter, buzz_out = buzz_in & alarmon.
// TESTING
// - Reset with adv_btn held high, release rst -> no adv pulse, mode_st=0; release and press adv in SET_MIN
//   -> minadv high exactly 1 cycle.
// - 8 mode_btn presses from RUN -> mode_st 1,2,...,7,0; timeset high for codes 1-5, alarmset for 6-7.
// - SET_HRS, adv held 6 cycles, HOLD_DLY=2 -> hrsadv pattern 1,0,1,1,1,1 (edge pulse, wait, repeat); 0 after release.
// - SET_DATE, no buttons for 30 cycles -> mode_st returns to 0 on cycle 30, dateadv stays 0.
// - Same-cycle mode and adv edges in SET_MIN -> mode_st=2, minadv=0, hrsadv=0.
// - SNOOZE_EN: alarmon=1, buzz_in=1, snooze edge -> buzz_out 0 for 300 cycles then 1;
//   without macro buzz_out follows buzz_in.

Source files
------------

// File: rtl/set_mode_ctrl_if.sv
// Button inputs and counter-chain controls of the alarm-clock front-panel sequencer.
interface set_mode_ctrl_if;
  logic       mode_btn;
  logic       adv_btn;
  logic       alarm_tgl;
  logic       snooze_btn;
  logic       buzz_in;
  logic       timeset;
  logic       alarmset;
  logic       minadv;
  logic       hrsadv;
  logic       dayadv;
  logic       dateadv;
  logic       monthadv;
  logic       alarmon;
  logic       buzz_out;
  logic [2:0] mode_st;

  modport master (
    output mode_btn, adv_btn, alarm_tgl, snooze_btn, buzz_in,
    input  timeset, alarmset, minadv, hrsadv, dayadv, dateadv, monthadv,
           alarmon, buzz_out, mode_st
  );

  modport slave (
    input  mode_btn, adv_btn, alarm_tgl, snooze_btn, buzz_in,
    output timeset, alarmset, minadv, hrsadv, dayadv, dateadv, monthadv,
           alarmon, buzz_out, mode_st
  );
endinterface

// File: rtl/set_mode_ctrl.sv
// Front-panel sequencer: mode stepping, advance with hold auto-repeat, idle timeout, alarm arm.
// Optional alarm snooze is built when the SNOOZE_EN macro is defined.
module set_mode_ctrl #(
  parameter int unsigned TIMEOUT    = 30,
  parameter int unsigned HOLD_DLY   = 2,
  parameter int unsigned SNOOZE_CYC = 300
) (
  input logic            clk,
  input logic            rst,
  set_mode_ctrl_if.slave bus
);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_DLY + 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_MIN   = 3'd1,
    SET_HRS   = 3'd2,
    SET_DAY   = 3'd3,
    SET_DATE  = 3'd4,
    SET_MONTH = 3'd5,
    AL_MIN    = 3'd6,
    AL_HRS    = 3'd7
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_mode_q, r_adv_q, r_tgl_q;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_armed, w_armed_nxt;
  logic                r_alarmon, w_alarmon_nxt;
  logic [4:0]          r_adv, w_adv_nxt;
  logic                r_timeset, r_alarmset, r_buzz;
  logic                w_buzz_nxt;
  logic                w_mode_e, w_adv_e, w_tgl_e, w_set, w_fire;

  assign w_mode_e = bus.mode_btn  & ~r_mode_q;
  assign w_adv_e  = bus.adv_btn   & ~r_adv_q;
  assign w_tgl_e  = bus.alarm_tgl & ~r_tgl_q;
  assign w_set    = (r_state != RUN);

  // Repeat only after an accepted press; armed drops on release or on a mode step.
  assign w_fire = w_set & ~w_mode_e &
                  (w_adv_e | (bus.adv_btn & r_armed & ((32'(r_hold) + 32'd1) >= HOLD_DLY)));

  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = '0;
    w_hold_nxt    = r_hold;
    w_armed_nxt   = r_armed;
    w_adv_nxt     = '0;
    w_alarmon_nxt = r_alarmon ^ w_tgl_e;
    if (!bus.adv_btn) begin
      w_hold_nxt  = '0;
      w_armed_nxt = 1'b0;
    end
    if (w_mode_e) begin
      w_state_nxt = state_t'(r_state + 3'd1);
      w_hold_nxt  = '0;
      w_armed_nxt = 1'b0;
    end else if (w_set) begin
      if (w_adv_e) begin
        w_hold_nxt  = '0;
        w_armed_nxt = 1'b1;
      end else if (bus.adv_btn && r_armed && (32'(r_hold) < HOLD_DLY)) begin
        w_hold_nxt = r_hold + 1'b1;
      end
      if (w_fire) begin
        case (r_state)
          SET_MIN, AL_MIN: w_adv_nxt[0] = 1'b1;
          SET_HRS, AL_HRS: w_adv_nxt[1] = 1'b1;
          SET_DAY:         w_adv_nxt[2] = 1'b1;
          SET_DATE:        w_adv_nxt[3] = 1'b1;
          SET_MONTH:       w_adv_nxt[4] = 1'b1;
          default:         w_adv_nxt    = '0;
        endcase
      end
      if (!(w_adv_e || w_tgl_e || bus.adv_btn)) begin
        if ((32'(r_idle) + 32'd1) >= TIMEOUT) begin
          w_state_nxt = RUN;
          w_hold_nxt  = '0;
          w_armed_nxt = 1'b0;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
      end
    end
  end

`ifdef SNOOZE_EN
  localparam int unsigned SNZ_W = $clog2(SNOOZE_CYC + 1);

  logic             r_snz_q;
  logic [SNZ_W-1:0] r_snz, w_snz_nxt;
  logic             w_snz_e;

  assign w_snz_e = bus.snooze_btn & ~r_snz_q;

  always_comb begin
    w_snz_nxt = r_snz;
    if (w_tgl_e && r_alarmon) begin
      w_snz_nxt = '0;
    end else if (w_snz_e && bus.buzz_in && r_alarmon) begin
      w_snz_nxt = SNZ_W'(SNOOZE_CYC);
    end else if (r_snz != '0) begin
      w_snz_nxt = r_snz - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snz_q <= 1'b1;
      r_snz   <= '0;
    end else begin
      r_snz_q <= bus.snooze_btn;
      r_snz   <= w_snz_nxt;
    end
  end

  assign w_buzz_nxt = bus.buzz_in & w_alarmon_nxt & (w_snz_nxt == '0);
`else
  logic w_unused_snooze;
  assign w_unused_snooze = bus.snooze_btn;
  assign w_buzz_nxt      = bus.buzz_in & w_alarmon_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_mode_q   <= 1'b1;
      r_adv_q    <= 1'b1;
      r_tgl_q    <= 1'b1;
      r_idle     <= '0;
      r_hold     <= '0;
      r_armed    <= 1'b0;
      r_alarmon  <= 1'b0;
      r_adv      <= '0;
      r_timeset  <= 1'b0;
      r_alarmset <= 1'b0;
      r_buzz     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode_q   <= bus.mode_btn;
      r_adv_q    <= bus.adv_btn;
      r_tgl_q    <= bus.alarm_tgl;
      r_idle     <= w_idle_nxt;
      r_hold     <= w_hold_nxt;
      r_armed    <= w_armed_nxt;
      r_alarmon  <= w_alarmon_nxt;
      r_adv      <= w_adv_nxt;
      r_timeset  <= (w_state_nxt >= SET_MIN) && (w_state_nxt <= SET_MONTH);
      r_alarmset <= (w_state_nxt == AL_MIN) || (w_state_nxt == AL_HRS);
      r_buzz     <= w_buzz_nxt;
    end
  end

  assign bus.mode_st  = r_state;
  assign bus.timeset  = r_timeset;
  assign bus.alarmset = r_alarmset;
  assign bus.minadv   = r_adv[0];
  assign bus.hrsadv   = r_adv[1];
  assign bus.dayadv   = r_adv[2];
  assign bus.dateadv  = r_adv[3];
  assign bus.monthadv = r_adv[4];
  assign bus.alarmon  = r_alarmon;
  assign bus.buzz_out = r_buzz;
endmodule

// File: tb/tb_set_mode_ctrl.sv
// Directed vector bench for set_mode_ctrl: table of {buttons, expected outputs} plus
// hand-written reset, idle-timeout and snooze sequences.
module tb_set_mode_ctrl;
  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_bad;

  set_mode_ctrl_if bus ();

  set_mode_ctrl #(
    .TIMEOUT    (30),
    .HOLD_DLY   (2),
    .SNOOZE_CYC (300)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {mode, adv, tgl, snooze, buzz}; exp = {st[2:0], ts, as, month, date, day, hrs, min, on, buzz}
  typedef struct {
    logic [4:0]  in;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] pk(input logic [2:0] st, input logic ts, input logic as_,
                                     input logic [4:0] adv, input logic on, input logic bz);
    return {st, ts, as_, adv, on, bz};
  endfunction

  task automatic add(input logic [4:0] in, input logic [11:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {bus.mode_st, bus.timeset, bus.alarmset, bus.monthadv, bus.dateadv,
           bus.dayadv, bus.hrsadv, bus.minadv, bus.alarmon, bus.buzz_out};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b (st,ts,as,mo,da,dy,hr,mi,on,bz)", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [4:0] in, input logic [11:0] exp);
    {bus.mode_btn, bus.adv_btn, bus.alarm_tgl, bus.snooze_btn, bus.buzz_in} = in;
    @(posedge clk);
    #1;
    compare(name, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;

    //    m a t s b               st ts as adv      on bz
    add(5'b01000, pk(3'd0, 0, 0, 5'b00000, 0, 0)); // adv held from reset: ignored
    add(5'b11000, pk(3'd1, 1, 0, 5'b00000, 0, 0)); // held adv gives no pulse in SET_MIN
    add(5'b11000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b01000, pk(3'd1, 1, 0, 5'b00001, 0, 0)); // fresh press: one minadv
    add(5'b01000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b10000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b01000, pk(3'd2, 1, 0, 5'b00010, 0, 0)); // hold: 1,0,1,1,1,1
    add(5'b01000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b01000, pk(3'd2, 1, 0, 5'b00010, 0, 0));
    add(5'b01000, pk(3'd2, 1, 0, 5'b00010, 0, 0));
    add(5'b01000, pk(3'd2, 1, 0, 5'b00010, 0, 0));
    add(5'b01000, pk(3'd2, 1, 0, 5'b00010, 0, 0));
    add(5'b00000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b00100, pk(3'd2, 1, 0, 5'b00000, 1, 0)); // alarm on
    add(5'b00001, pk(3'd2, 1, 0, 5'b00000, 1, 1));
    add(5'b00000, pk(3'd2, 1, 0, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd3, 1, 0, 5'b00000, 1, 0));
    add(5'b01000, pk(3'd3, 1, 0, 5'b00100, 1, 0));
    add(5'b00000, pk(3'd3, 1, 0, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd4, 1, 0, 5'b00000, 1, 0));
    add(5'b01000, pk(3'd4, 1, 0, 5'b01000, 1, 0));
    add(5'b00000, pk(3'd4, 1, 0, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd5, 1, 0, 5'b00000, 1, 0));
    add(5'b01000, pk(3'd5, 1, 0, 5'b10000, 1, 0));
    add(5'b00000, pk(3'd5, 1, 0, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd6, 0, 1, 5'b00000, 1, 0));
    add(5'b01000, pk(3'd6, 0, 1, 5'b00001, 1, 0));
    add(5'b00000, pk(3'd6, 0, 1, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd7, 0, 1, 5'b00000, 1, 0));
    add(5'b01000, pk(3'd7, 0, 1, 5'b00010, 1, 0));
    add(5'b00000, pk(3'd7, 0, 1, 5'b00000, 1, 0));
    add(5'b10000, pk(3'd0, 0, 0, 5'b00000, 1, 0)); // AL_HRS wraps to RUN
    add(5'b01000, pk(3'd0, 0, 0, 5'b00000, 1, 0)); // adv ignored in RUN
    add(5'b00001, pk(3'd0, 0, 0, 5'b00000, 1, 1));
    add(5'b00101, pk(3'd0, 0, 0, 5'b00000, 0, 0)); // alarm off masks buzz
    add(5'b10000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd1, 1, 0, 5'b00000, 0, 0));
    add(5'b11000, pk(3'd2, 1, 0, 5'b00000, 0, 0)); // mode and adv together: mode wins
    add(5'b11000, pk(3'd2, 1, 0, 5'b00000, 0, 0)); // no repeat until re-press
    add(5'b11000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd2, 1, 0, 5'b00000, 0, 0));
    add(5'b10000, pk(3'd3, 1, 0, 5'b00000, 0, 0));
    add(5'b00000, pk(3'd3, 1, 0, 5'b00000, 0, 0));
    add(5'b10000, pk(3'd4, 1, 0, 5'b00000, 0, 0)); // enter SET_DATE for timeout

    rst = 1'b0;
    {bus.mode_btn, bus.adv_btn, bus.alarm_tgl, bus.snooze_btn, bus.buzz_in} = 5'b01000;
    repeat (2) @(posedge clk);
    #1;
    compare("reset", pk(3'd0, 0, 0, 5'b00000, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    for (int i = 1; i <= 30; i++) begin
      if (i < 30) step($sformatf("idle%0d", i), 5'b00000, pk(3'd4, 1, 0, 5'b00000, 0, 0));
      else        step("timeout", 5'b00000, pk(3'd0, 0, 0, 5'b00000, 0, 0));
    end
    step("after_timeout", 5'b00000, pk(3'd0, 0, 0, 5'b00000, 0, 0));

`ifdef SNOOZE_EN
    step("snz_arm", 5'b00101, pk(3'd0, 0, 0, 5'b00000, 1, 1));
    step("snz_press", 5'b00011, pk(3'd0, 0, 0, 5'b00000, 1, 0));
    for (int i = 1; i < 300; i++) begin
      step($sformatf("snz_mask%0d", i), 5'b00001, pk(3'd0, 0, 0, 5'b00000, 1, 0));
    end
    step("snz_expire", 5'b00001, pk(3'd0, 0, 0, 5'b00000, 1, 1));
    step("snz_off", 5'b00101, pk(3'd0, 0, 0, 5'b00000, 0, 0));
`else
    step("buzz_arm", 5'b00101, pk(3'd0, 0, 0, 5'b00000, 1, 1));
    step("buzz_snz_ign", 5'b00011, pk(3'd0, 0, 0, 5'b00000, 1, 1));
    step("buzz_follow", 5'b00000, pk(3'd0, 0, 0, 5'b00000, 1, 0));
    step("buzz_off", 5'b00101, pk(3'd0, 0, 0, 5'b00000, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
